// File: rtl/router_pkg.sv
// Shared types and helpers for the mesh router port scheduler.
// Flit encoding, port indices and the XY routing decision.
package router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int COORD_W   = 4;
  localparam int FLIT_W    = 32;
  localparam int PW        = 3;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [PW-1:0]     port_t;

  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam port_t P_LOCAL = 3'd0;
  localparam port_t P_NORTH = 3'd1;
  localparam port_t P_EAST  = 3'd2;
  localparam port_t P_SOUTH = 3'd3;
  localparam port_t P_WEST  = 3'd4;

  typedef enum logic {OUT_FREE, OUT_LOCKED} out_st_e;
  typedef enum logic {IN_IDLE, IN_ACTIVE} in_st_e;

  function automatic port_t xy_route(
    input logic [COORD_W-1:0] cur_x,
    input logic [COORD_W-1:0] cur_y,
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y
  );
    if (dst_x > cur_x)      return P_EAST;
    else if (dst_x < cur_x) return P_WEST;
    else if (dst_y > cur_y) return P_NORTH;
    else if (dst_y < cur_y) return P_SOUTH;
    else                    return P_LOCAL;
  endfunction

endpackage

// File: rtl/router_port_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester
// found when searching upward from the pointer, with wrap.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int N = NUM_PORTS
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  localparam logic [PW:0] NW = (PW+1)'(N);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      idx = (sum >= NW) ? PW'(sum - NW) : PW'(sum);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_port_scheduler.sv
// Per-router XY route, per-output round-robin arbitration
// and wormhole locking feeding one-entry output registers.
module router_port_scheduler
  import router_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COORD_W-1:0]            cur_x,
  input  logic [COORD_W-1:0]            cur_y,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS*FLIT_W-1:0]   in_flit,
  output logic [NUM_PORTS-1:0]          out_valid,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS*FLIT_W-1:0]   out_flit,
  output logic                          err
);

  localparam int NP = NUM_PORTS;

  flit_t      fl     [NP];
  logic [1:0] ft     [NP];
  logic [NP-1:0] hd;
  port_t      rte    [NP];

  in_st_e     ist_q  [NP];
  port_t      irt_q  [NP];
  out_st_e    ost_q  [NP];
  port_t      own_q  [NP];
  port_t      rr_q   [NP];
  logic [NP-1:0] ov_q;
  flit_t      of_q   [NP];
  logic       err_q;

  logic [NP-1:0] can_ld;
  logic [NP-1:0] ld;
  flit_t      ld_dat [NP];
  logic [NP-1:0] req [NP];
  logic [NP-1:0] gnt [NP];
  port_t      win    [NP];
  logic       err_set;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      fl[p]  = in_flit[p*FLIT_W +: FLIT_W];
      ft[p]  = fl[p][FLIT_W-1 -: 2];
      hd[p]  = (ft[p] == FT_HEAD) || (ft[p] == FT_SINGLE);
      rte[p] = xy_route(cur_x, cur_y,
                        fl[p][2*COORD_W-1:COORD_W],
                        fl[p][COORD_W-1:0]);
    end
  end

  assign can_ld = ~ov_q | out_ready;

  // Only idle heads compete, and only for a free output that can load
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      req[o] = '0;
      for (int p = 0; p < NP; p++) begin
        req[o][p] = in_valid[p] && hd[p]
                 && (ist_q[p] == IN_IDLE)
                 && (rte[p] == port_t'(o))
                 && (ost_q[o] == OUT_FREE)
                 && can_ld[o];
      end
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_arb
    rr_arbiter #(.N(NP)) u_arb (
      .req_i (req[o]),
      .ptr_i (rr_q[o]),
      .gnt_o (gnt[o])
    );
  end

  always_comb begin
    in_ready = '0;
    ld       = '0;
    err_set  = 1'b0;
    for (int o = 0; o < NP; o++) begin
      ld_dat[o] = '0;
      win[o]    = '0;
      for (int p = 0; p < NP; p++)
        if (gnt[o][p]) win[o] = port_t'(p);
      if (ost_q[o] == OUT_LOCKED) begin
        if (in_valid[own_q[o]] && !hd[own_q[o]] && can_ld[o]) begin
          ld[o]     = 1'b1;
          ld_dat[o] = fl[own_q[o]];
        end
      end else if (|gnt[o]) begin
        ld[o]     = 1'b1;
        ld_dat[o] = fl[win[o]];
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (in_valid[p]) begin
        if (ist_q[p] == IN_ACTIVE) begin
          if (hd[p]) err_set = 1'b1;
          else       in_ready[p] = can_ld[irt_q[p]];
        end else if (!hd[p]) begin
          in_ready[p] = 1'b1;
          err_set     = 1'b1;
        end else begin
          in_ready[p] = gnt[rte[p]][p];
        end
      end
    end
    if (rst) begin
      in_ready = '0;
      err_set  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        of_q[i]  <= '0;
        ist_q[i] <= IN_IDLE;
        irt_q[i] <= '0;
        ost_q[i] <= OUT_FREE;
        own_q[i] <= '0;
        rr_q[i]  <= '0;
      end
    end else begin
      err_q <= err_q | err_set;
      for (int o = 0; o < NP; o++) begin
        if (ld[o]) begin
          ov_q[o] <= 1'b1;
          of_q[o] <= ld_dat[o];
        end else if (out_ready[o]) begin
          ov_q[o] <= 1'b0;
        end
        if (|gnt[o])
          rr_q[o] <= (win[o] == port_t'(NP-1)) ? '0 : win[o] + 1'b1;
      end
      for (int p = 0; p < NP; p++) begin
        if (in_valid[p] && in_ready[p]) begin
          if (ist_q[p] == IN_ACTIVE && ft[p] == FT_TAIL) begin
            ist_q[p]        <= IN_IDLE;
            ost_q[irt_q[p]] <= OUT_FREE;
          end
          if (ist_q[p] == IN_IDLE && ft[p] == FT_HEAD) begin
            ist_q[p]      <= IN_ACTIVE;
            irt_q[p]      <= rte[p];
            ost_q[rte[p]] <= OUT_LOCKED;
            own_q[rte[p]] <= port_t'(p);
          end
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++)
      out_flit[o*FLIT_W +: FLIT_W] = of_q[o];
  end
  assign out_valid = ov_q;
  assign err       = err_q;

endmodule

// File: tb/tb_router_port_scheduler.sv
// Scoreboard bench for router_port_scheduler: directed scenarios
// followed by randomized packet traffic against a behavioural model.
module tb_router_port_scheduler;
  import router_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cx, cy;
  logic [4:0]   iv, ir, ov, ordy;
  logic [159:0] ifl, ofl;
  logic         err;
  flit_t        fl [5];

  always #5 clk = ~clk;

  always_comb
    for (int p = 0; p < 5; p++) ifl[p*32 +: 32] = fl[p];

  router_port_scheduler dut (
    .clk(clk), .rst(rst), .cur_x(cx), .cur_y(cy),
    .in_valid(iv), .in_ready(ir), .in_flit(ifl),
    .out_valid(ov), .out_ready(ordy), .out_flit(ofl),
    .err(err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic flit_t mk(logic [1:0] t, int dx, int dy, int pl);
    return {t, 22'(pl), 4'(dx), 4'(dy)};
  endfunction

  function automatic flit_t ofs(int o);
    return ofl[o*32 +: 32];
  endfunction

  // XY rule: X is resolved first, then Y, unsigned compare
  function automatic int ref_route(int curx, int cury, int dx, int dy);
    if (dx > curx) return 2;
    if (dx < curx) return 4;
    if (dy > cury) return 1;
    if (dy < cury) return 3;
    return 0;
  endfunction

  // ---------------- reference model + monitor ----------------
  flit_t expq [5][$];
  bit    m_act [5];
  int    m_dst [5];
  bit    m_lock [5];
  bit    m_err;
  bit    prev_hold [5];
  flit_t prev_fl [5];

  always @(negedge clk) begin : mon
    bit lk_nx [5];
    bit taken [5];
    logic [1:0] t;
    int d;
    flit_t f;
    chk("err", err, m_err);
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        expq[o].delete();
        m_act[o] = 0;
        m_lock[o] = 0;
        prev_hold[o] = 0;
      end
      m_err = 0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (prev_hold[o]) begin
          chk("hold_valid", ov[o], 1);
          chk("hold_flit", ofs(o), prev_fl[o]);
        end
        if (ov[o] && ordy[o]) begin
          if (expq[o].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL out_unexpected port %0d: got %0h required none",
                     o, ofs(o));
          end else begin
            f = expq[o].pop_front();
            chk("out_flit", ofs(o), f);
          end
        end
        prev_hold[o] = ov[o] && !ordy[o];
        prev_fl[o]   = ofs(o);
        lk_nx[o]     = m_lock[o];
        taken[o]     = 0;
      end
      for (int p = 0; p < 5; p++) begin
        if (iv[p]) begin
          t = fl[p][31:30];
          if (m_act[p]) begin
            if (t == FT_HEAD || t == FT_SINGLE) begin
              chk("busy_head_rdy", ir[p], 0);
              m_err = 1;
            end else if (ir[p]) begin
              expq[m_dst[p]].push_back(fl[p]);
              if (t == FT_TAIL) begin
                m_act[p] = 0;
                lk_nx[m_dst[p]] = 0;
              end
            end
          end else if (t == FT_BODY || t == FT_TAIL) begin
            chk("idle_body_rdy", ir[p], 1);
            m_err = 1;
          end else if (ir[p]) begin
            d = ref_route(int'(cx), int'(cy),
                          int'(fl[p][7:4]), int'(fl[p][3:0]));
            chk("lock_viol", m_lock[d], 0);
            chk("dup_grant", taken[d], 0);
            taken[d] = 1;
            expq[d].push_back(fl[p]);
            if (t == FT_HEAD) begin
              m_act[p] = 1;
              m_dst[p] = d;
              lk_nx[d] = 1;
            end
          end
        end
      end
      for (int o = 0; o < 5; o++) m_lock[o] = lk_nx[o];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int nx, int ny);
    step();
    rst = 1;
    iv  = '0;
    cx  = 4'(nx);
    cy  = 4'(ny);
    step();
    rst = 0;
  endtask

  task automatic single_route(int dx, int dy, int exp_p, int pl);
    flit_t f;
    f = mk(FT_SINGLE, dx, dy, pl);
    step();
    fl[0] = f;
    iv[0] = 1;
    @(negedge clk);
    chk("route_rdy", ir[0], 1);
    step();
    iv[0] = 0;
    @(negedge clk);
    chk("route_valid", ov, 5'(1) << exp_p);
    chk("route_flit", ofs(exp_p), f);
  endtask

  // ---------------- random traffic state ----------------
  int  left_n [5];
  int  plen [5];
  bit  first [5];
  bit  stray [5];
  int  rdx [5], rdy [5];
  logic [4:0] acc;
  int  pay = 1000;

  task automatic gen_cycle(bit draining);
    logic [1:0] t;
    for (int p = 0; p < 5; p++) begin
      if (iv[p] && acc[p] && !stray[p]) begin
        left_n[p]--;
        first[p] = 0;
      end
      if (acc[p] || stray[p]) iv[p] = 0;
      stray[p] = 0;
      if (!iv[p]) begin
        if (left_n[p] == 0 && !draining && $urandom_range(0, 3) == 0) begin
          plen[p]   = $urandom_range(1, 4);
          left_n[p] = plen[p];
          first[p]  = 1;
          rdx[p]    = $urandom_range(0, 15);
          rdy[p]    = $urandom_range(0, 15);
        end
        if (!draining && left_n[p] > 0 && !first[p]
            && $urandom_range(0, 29) == 0) begin
          fl[p] = mk(FT_HEAD, $urandom_range(0, 15), 3, pay++);
          iv[p] = 1;
          stray[p] = 1;
        end else if (!draining && left_n[p] == 0
                     && $urandom_range(0, 49) == 0) begin
          fl[p] = mk(FT_BODY, 0, 0, pay++);
          iv[p] = 1;
          stray[p] = 1;
        end else if (left_n[p] > 0 && $urandom_range(0, 3) != 0) begin
          if (first[p]) t = (plen[p] == 1) ? FT_SINGLE : FT_HEAD;
          else          t = (left_n[p] == 1) ? FT_TAIL : FT_BODY;
          fl[p] = mk(t, rdx[p], rdy[p], pay++);
          iv[p] = 1;
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  flit_t seq [6];
  flit_t pk [6];
  flit_t held;
  int    ord [6] = '{1, 2, 3, 1, 2, 3};
  int    idx, busy;
  bit    acc1;

  initial begin
    rst  = 1;
    iv   = '0;
    ordy = '1;
    cx   = 4'd2;
    cy   = 4'd2;
    for (int p = 0; p < 5; p++) fl[p] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", ov, 0);
    chk("reset_out_flit", ofl, 0);
    chk("reset_in_ready", ir, 0);
    chk("reset_err", err, 0);
    step();
    rst = 0;

    // routing from cur=(2,2)
    single_route(5, 1, 2, 11);
    single_route(2, 7, 1, 12);
    single_route(2, 2, 0, 13);
    single_route(0, 9, 4, 14);

    // wormhole lock on EAST: NORTH owns it, SOUTH waits for the tail
    seq[0] = mk(FT_HEAD, 5, 2, 21);
    seq[1] = mk(FT_BODY, 0, 0, 22);
    seq[2] = mk(FT_BODY, 0, 0, 23);
    seq[3] = mk(FT_TAIL, 0, 0, 24);
    seq[4] = mk(FT_HEAD, 6, 0, 31);
    seq[5] = mk(FT_TAIL, 0, 0, 32);
    for (int c = 0; c < 7; c++) begin
      step();
      iv[1] = (c < 4);
      fl[1] = (c < 4) ? seq[c] : '0;
      iv[3] = (c >= 1 && c <= 5);
      fl[3] = (c == 5) ? seq[5] : seq[4];
      @(negedge clk);
      if (c >= 1 && c <= 5) chk("wh_south_rdy", ir[3], (c >= 4));
      if (c >= 1) begin
        chk("wh_out_valid", ov[2], 1);
        chk("wh_out_flit", ofs(2), seq[c-1]);
      end
    end

    // round-robin on LOCAL from a fresh pointer
    do_reset(2, 2);
    for (int p = 1; p < 4; p++) begin
      fl[p] = mk(FT_SINGLE, 2, 2, 100 + p);
      iv[p] = 1;
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", ir, 5'(1) << ord[k]);
      acc = ir;
      step();
      for (int p = 1; p < 4; p++)
        if (acc[p]) fl[p] = mk(FT_SINGLE, 2, 2, 200 + 10*k + p);
    end
    iv = '0;

    // backpressure on EAST mid-packet
    pk[0] = mk(FT_HEAD, 9, 3, 301);
    for (int i = 1; i < 5; i++) pk[i] = mk(FT_BODY, 0, 0, 301 + i);
    pk[5] = mk(FT_TAIL, 0, 0, 306);
    step();
    idx   = 0;
    fl[1] = pk[0];
    iv[1] = 1;
    held  = '0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      ordy[2] = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c == 3) held = ofs(2);
      if (c >= 3 && c <= 5) begin
        chk("bp_in_rdy", ir[1], 0);
        chk("bp_out_valid", ov[2], 1);
        chk("bp_out_hold", ofs(2), held);
      end
      acc1 = iv[1] && ir[1];
      step();
      if (acc1) idx++;
      iv[1] = (idx < 6);
      fl[1] = (idx < 6) ? pk[idx] : '0;
    end
    chk("bp_all_sent", idx, 6);
    ordy = '1;
    repeat (3) step();
    for (int o = 0; o < 5; o++) chk("bp_drained", expq[o].size(), 0);

    // BODY at an idle input
    do_reset(2, 2);
    @(negedge clk);
    chk("perr_pre", err, 0);
    step();
    fl[2] = mk(FT_BODY, 5, 5, 401);
    iv[2] = 1;
    @(negedge clk);
    chk("perr_consumed", ir[2], 1);
    step();
    iv[2] = 0;
    @(negedge clk);
    chk("perr_no_out", ov, 0);
    chk("perr_err", err, 1);
    repeat (10) @(negedge clk);
    chk("perr_sticky", err, 1);

    // reset in the middle of a packet
    do_reset(2, 2);
    fl[1] = mk(FT_HEAD, 9, 2, 501);
    iv[1] = 1;
    @(negedge clk);
    chk("mrst_head_rdy", ir[1], 1);
    step();
    iv[1] = 0;
    rst   = 1;
    @(negedge clk);
    chk("mrst_loaded", ov[2], 1);
    step();
    rst   = 0;
    fl[3] = mk(FT_HEAD, 8, 1, 601);
    iv[3] = 1;
    @(negedge clk);
    chk("mrst_out_cleared", ov, 0);
    chk("mrst_new_head_rdy", ir[3], 1);
    step();
    fl[3] = mk(FT_TAIL, 0, 0, 602);
    @(negedge clk);
    chk("mrst_new_head_out", ofs(2), mk(FT_HEAD, 8, 1, 601));
    chk("mrst_tail_rdy", ir[3], 1);
    step();
    iv[3] = 0;
    @(negedge clk);
    chk("mrst_tail_out", ofs(2), mk(FT_TAIL, 0, 0, 602));

    // randomized traffic
    do_reset($urandom_range(0, 15), $urandom_range(0, 15));
    for (int p = 0; p < 5; p++) begin
      left_n[p] = 0;
      first[p]  = 0;
      stray[p]  = 0;
    end
    acc = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int o = 0; o < 5; o++) ordy[o] = ($urandom_range(0, 3) != 0);
      gen_cycle(0);
      @(negedge clk);
      acc = iv & ir;
      step();
    end
    ordy = '1;
    busy = 1;
    for (int c = 0; c < 400 && busy != 0; c++) begin
      gen_cycle(1);
      @(negedge clk);
      acc  = iv & ir;
      busy = 0;
      for (int p = 0; p < 5; p++)
        if (left_n[p] != 0 || iv[p]) busy++;
      step();
    end
    chk("rand_drain_done", busy, 0);
    iv = '0;
    repeat (4) step();
    for (int o = 0; o < 5; o++) chk("rand_drained", expq[o].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
